// File: rtl/hdlc_frame_detector.sv
// HDLC receive-path monitor: counts consecutive 1s on a serial bit stream and
// flags stuffed-zero discards, frame flags and abort/error runs (Moore FSM).
module hdlc_frame_detector (
  input  logic clk,
  input  logic reset,
  input  logic in,
  output logic disc,
  output logic flag,
  output logic err
);

  typedef enum logic [3:0] {
    S0     = 4'd0,
    S1     = 4'd1,
    S2     = 4'd2,
    S3     = 4'd3,
    S4     = 4'd4,
    S5     = 4'd5,
    S6     = 4'd6,
    S_ERR  = 4'd7,
    S_DISC = 4'd8,
    S_FLAG = 4'd9
  } state_e;

  state_e state_q;
  state_e state_d;

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge value of its inputs, regardless of process ordering.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S0;
    end else begin
      state_q <= state_d;
    end
  end

  // NOTE: state_d gets a default before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d = S0;
    unique case (state_q)
      S0:      state_d = in ? S1     : S0;
      S1:      state_d = in ? S2     : S0;
      S2:      state_d = in ? S3     : S0;
      S3:      state_d = in ? S4     : S0;
      S4:      state_d = in ? S5     : S0;
      S5:      state_d = in ? S6     : S_DISC;
      S6:      state_d = in ? S_ERR  : S_FLAG;
      S_ERR:   state_d = in ? S_ERR  : S0;
      // The terminating 0 of a discard or flag doubles as the leading 0 of
      // the next run, so a following 1 is already the first counted 1.
      S_DISC:  state_d = in ? S1     : S0;
      S_FLAG:  state_d = in ? S1     : S0;
      default: state_d = S0;
    endcase
  end

  always_comb begin
    disc = (state_q == S_DISC);
    flag = (state_q == S_FLAG);
    err  = (state_q == S_ERR);
  end

endmodule

// File: tb/tb_hdlc_frame_detector.sv
// Scoreboard bench for hdlc_frame_detector: a run-length reference model
// feeds expected {disc,flag,err} into a queue drained by a negedge monitor.
module tb_hdlc_frame_detector;

  typedef struct {
    logic  disc;
    logic  flag;
    logic  err;
    string tag;
  } exp_t;

  logic clk;
  logic reset;
  logic in;
  logic disc;
  logic flag;
  logic err;

  hdlc_frame_detector dut (
    .clk   (clk),
    .reset (reset),
    .in    (in),
    .disc  (disc),
    .flag  (flag),
    .err   (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  exp_t  sb_q[$];
  exp_t  pending;
  bit    pending_v;
  int    ones;
  int    total;
  int    bad;
  string cur_tag;

  task automatic check(input string name, input logic [2:0] act, input logic [2:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got disc/flag/err=%b expected %b at %0t", name, act, req, $time);
    end
  endtask

  // Reference: the number of consecutive 1s since the last 0 decides
  // everything; a 0 ends the run with disc (5 ones) or flag (6 ones).
  function automatic exp_t model_step(input logic r, input logic b);
    exp_t e;
    e.disc = 1'b0;
    e.flag = 1'b0;
    e.err  = 1'b0;
    e.tag  = cur_tag;
    if (r) begin
      ones = 0;
    end else if (b) begin
      if (ones < 100) ones++;
      e.err = (ones >= 7);
    end else begin
      e.disc = (ones == 5);
      e.flag = (ones == 6);
      ones = 0;
    end
    return e;
  endfunction

  // One clock per call: the expectation for the edge just taken is queued at
  // that edge, then new inputs are applied 1 time unit later.
  task automatic step(input logic r, input logic b);
    @(posedge clk);
    if (pending_v) sb_q.push_back(pending);
    #1;
    reset = r;
    in    = b;
    pending   = model_step(r, b);
    pending_v = 1'b1;
  endtask

  task automatic send_bits(input string tag, input string bits);
    cur_tag = tag;
    for (int i = 0; i < bits.len(); i++) begin
      step(1'b0, bits[i] == "1");
    end
  endtask

  task automatic do_reset(input string tag, input logic b);
    cur_tag = tag;
    step(1'b1, b);
  endtask

  // Monitor: outputs are stable between edges; compare at each falling edge.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        check(e.tag, {disc, flag, err}, {e.disc, e.flag, e.err});
      end
    end
  end

  initial begin
    total     = 0;
    bad       = 0;
    ones      = 0;
    pending_v = 1'b0;
    reset     = 1'b1;
    in        = 1'b0;
    cur_tag   = "reset";

    do_reset("reset", 1'b0);
    do_reset("reset", 1'b0);

    send_bits("disc", "0111110");
    send_bits("disc_idle", "00");

    do_reset("reset2", 1'b0);
    send_bits("flag", "01111110");
    send_bits("flag_idle", "0");

    do_reset("reset3", 1'b0);
    send_bits("err", "011111111");
    send_bits("err_release", "00");

    do_reset("reset4", 1'b0);
    send_bits("b2b", "01111110111110");
    send_bits("b2b_idle", "0");

    do_reset("reset5", 1'b0);
    send_bits("mid_reset", "011111");
    do_reset("mid_reset_hi", 1'b1);
    send_bits("after_reset", "0");
    send_bits("mid_reset", "11111");
    do_reset("mid_reset_hi", 1'b1);
    send_bits("count_from_s1", "1111110");

    cur_tag = "random";
    for (int i = 0; i < 3000; i++) begin
      logic r;
      logic b;
      r = ($urandom_range(31) == 0);
      b = ($urandom_range(3) != 0);
      step(r, b);
    end

    cur_tag = "drain";
    step(1'b0, 1'b0);
    @(posedge clk);
    sb_q.push_back(pending);
    pending_v = 1'b0;
    repeat (3) @(negedge clk);

    total++;
    if (sb_q.size() != 0) begin
      bad++;
      $display("FAIL drain: %0d expectations left, expected 0", sb_q.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
